ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Bus initiator for the 32-bit data RAM. It turns single load/store and block-fill requests from the core into RAM address, write and value cycles, then returns a response.
- The RAM writes on the falling clock edge and reads combinationally. This block launches every access from the rising edge so that each write lands at the mid-cycle falling edge.
- Sits between the core's load/store path and the RAM.

Parameters:
- ADDR_W, 10: RAM address width.
- DATA_W, 32: data word width.
- LEN_W, 10: width of the fill-length field.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  2  request type: 00 read, 01 write, 10 fill, 11 illegal.
- req_addr  in  ADDR_W  start address.
- req_data  in  DATA_W  write or fill value.
- req_len  in  LEN_W  fill word count.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_data  out  DATA_W  response data: read data, fill count, or 0.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- busy  out  1  state is not IDLE.
- ram_addr  out  ADDR_W  RAM address.
- ram_write  out  1  RAM write enable.
- ram_value  out  DATA_W  RAM write data.
- ram_result  in  DATA_W  RAM combinational read data.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. On reset, state is IDLE and every output register clears to 0, except req_ready, which is 1.
- Reset in the middle of an operation abandons it: ram_write drops immediately and no response is issued.
- All RAM-side outputs are registered; none are driven combinationally from req_*.
- States: IDLE, ACCESS, FILL, RESP.
- IDLE:
  - req_ready=1, ram_write=0.
  - A request is accepted at rising edge k when req_valid is high. All req_* fields are latched at that edge.
- Read (00):
  - After edge k: ACCESS, ram_addr=req_addr, ram_write=0.
  - Edge k+1: rsp_data<=ram_result, go to RESP.
- Write (01):
  - After edge k: ACCESS, ram_addr=req_addr, ram_value=req_data, ram_write=1. The RAM captures the word at the falling edge inside that cycle.
  - Edge k+1: ram_write<=0, rsp_data<=0, go to RESP.
- Fill (10):
  - If req_len=0: go straight to RESP with rsp_data=0; no RAM cycles.
  - Otherwise enter FILL with ram_write=1 for exactly req_len consecutive cycles. ram_value=req_data throughout.
  - ram_addr starts at req_addr and increments by 1 each cycle, wrapping modulo 2^ADDR_W (1023 goes to 0).
  - Edge k+req_len: ram_write<=0, rsp_data<=req_len zero-extended, go to RESP.
- Illegal op (11): go to RESP with rsp_err=1 and rsp_data=0. No RAM cycle is issued.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready is high at a rising edge.
  - On that edge: rsp_valid<=0, rsp_err<=0, go to IDLE.
  - rsp_ready already high when rsp_valid rises gives exactly one cycle of rsp_valid.
- No request is accepted while busy. The next request can be accepted at the earliest on the edge after the one that returns to IDLE.
- req_valid asserted outside IDLE is ignored and is not queued.
- ram_addr holds its last value in IDLE and RESP.

Optional Feature:
- Macro: RAM_MASTER_READBACK_EN.
- When defined, a single write adds a VERIFY state:
  - After the write cycle, spend one cycle with ram_write=0 at the same address.
  - Capture ram_result at the following edge and set rsp_data to the read-back value.
  - Set rsp_err=1 if the read-back value differs from req_data.
  - Write latency becomes 2 cycles from acceptance to RESP.
- Fill requests are never verified.
- When undefined, the VERIFY state does not exist, write latency is 1 cycle, and rsp_data=0 for writes.

Test Plan:
1. Write 0xDEADBEEF to address 5, then read address 5: write gives rsp_valid 1 cycle after acceptance with rsp_data=0; read gives rsp_data=0xDEADBEEF with rsp_err=0.
2. Fill addr=1021, len=5, data=0xA5A5A5A5: ram_write high for 5 cycles at addresses 1021, 1022, 1023, 0, 1; rsp_data=5. Reading address 0 then returns 0xA5A5A5A5.
3. Fill with len=0: RESP with rsp_data=0 and ram_write never asserts.
4. Request with op=11: rsp_err=1, no ram_write pulse, and the block returns to IDLE after the response handshake.
5. Hold rsp_ready low for 4 cycles after a read: rsp_valid and rsp_data stay stable, req_ready stays low, and a second req_valid is not accepted. After rsp_ready rises, the block returns to IDLE and the next request is accepted one edge later.
6. Assert reset during the third cycle of a len=8 fill: ram_write falls to 0 immediately, no response is issued, and after reset is released req_ready=1. With RAM_MASTER_READBACK_EN defined, additionally check that a write of 0x12345678 to address 3 responds with rsp_data=0x12345678 and rsp_err=0.

Source files
------------

// File: rtl/ram_master_if.sv
// Core-side request/response channel and RAM-side bus of ram_master.
// The master modport is the block's view; slave is the core/RAM side.
interface ram_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_write;
    logic [DATA_W-1:0] ram_value;
    logic [DATA_W-1:0] ram_result;

    modport master (
        input  req_valid, req_op, req_addr, req_data, req_len, rsp_ready, ram_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_addr, ram_write, ram_value
    );

    modport slave (
        output req_valid, req_op, req_addr, req_data, req_len, rsp_ready, ram_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_addr, ram_write, ram_value
    );
endinterface

// File: rtl/ram_master.sv
// RAM bus initiator: single read/write, block fill and illegal-op responses.
// Define RAM_MASTER_READBACK_EN to read back and compare every single write.
module ram_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input logic          clock,
    input logic          reset,
    ram_master_if.master bus
);

`ifdef RAM_MASTER_READBACK_EN
    typedef enum logic [2:0] {IDLE, ACCESS, FILL, VERIFY, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, FILL, RESP} state_t;
`endif

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_FILL    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              write_q, write_n;
    logic [DATA_W-1:0] value_q, value_n;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_n;
    logic              rsp_err_q, rsp_err_n;
    logic              is_write_q, is_write_n;
    logic [LEN_W-1:0]  cnt_q, cnt_n;
    logic [LEN_W-1:0]  len_q, len_n;

    // NOTE: every always_comb target gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        write_n    = write_q;
        value_n    = value_q;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        is_write_n = is_write_q;
        cnt_n      = cnt_q;
        len_n      = len_q;

        unique case (state)
            IDLE: begin
                write_n = 1'b0;
                if (bus.req_valid) begin
                    unique case (op_t'(bus.req_op))
                        OP_READ: begin
                            state_n    = ACCESS;
                            addr_n     = bus.req_addr;
                            is_write_n = 1'b0;
                        end
                        OP_WRITE: begin
                            state_n    = ACCESS;
                            addr_n     = bus.req_addr;
                            value_n    = bus.req_data;
                            write_n    = 1'b1;
                            is_write_n = 1'b1;
                        end
                        OP_FILL: begin
                            len_n = bus.req_len;
                            if (bus.req_len == '0) begin
                                state_n    = RESP;
                                rsp_data_n = '0;
                                rsp_err_n  = 1'b0;
                            end else begin
                                state_n = FILL;
                                addr_n  = bus.req_addr;
                                value_n = bus.req_data;
                                write_n = 1'b1;
                                cnt_n   = bus.req_len;
                            end
                        end
                        OP_ILLEGAL: begin
                            state_n    = RESP;
                            rsp_data_n = '0;
                            rsp_err_n  = 1'b1;
                        end
                    endcase
                end
            end
            ACCESS: begin
                write_n = 1'b0;
                if (is_write_q) begin
`ifdef RAM_MASTER_READBACK_EN
                    state_n = VERIFY;
`else
                    state_n    = RESP;
                    rsp_data_n = '0;
`endif
                end else begin
                    state_n    = RESP;
                    rsp_data_n = bus.ram_result;
                end
            end
            FILL: begin
                // cnt_q counts the write cycles still to run, including the current one.
                if (cnt_q == LEN_W'(1)) begin
                    state_n    = RESP;
                    write_n    = 1'b0;
                    rsp_data_n = DATA_W'(len_q);
                end else begin
                    cnt_n  = cnt_q - LEN_W'(1);
                    addr_n = addr_q + ADDR_W'(1);
                end
            end
`ifdef RAM_MASTER_READBACK_EN
            VERIFY: begin
                state_n    = RESP;
                rsp_data_n = bus.ram_result;
                rsp_err_n  = (bus.ram_result != value_q);
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n   = IDLE;
                    rsp_err_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            value_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            is_write_q <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            write_q    <= write_n;
            value_q    <= value_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            is_write_q <= is_write_n;
            cnt_q      <= cnt_n;
            len_q      <= len_n;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_write = write_q;
    assign bus.ram_value = value_q;

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: falling-edge-write RAM, transaction-level
// memory model, directed scenarios followed by randomized traffic.
module tb_ram_master;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 10;
    localparam int DEPTH  = 1 << ADDR_W;

`ifdef RAM_MASTER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    ram_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    ram_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Environment RAM: writes on the falling edge, reads combinationally.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] model   [DEPTH];
    wr_t               wlog [$];

    assign bus.ram_result = ram_mem[bus.ram_addr];

    always @(negedge clock) begin
        if (bus.ram_write === 1'b1) begin
            ram_mem[bus.ram_addr] = bus.ram_value;
            wlog.push_back('{a: bus.ram_addr, d: bus.ram_value});
        end
    end

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // One full transaction; hold < 0 keeps rsp_ready high from the start,
    // hold > 0 stalls the response that many cycles while a stray request is offered.
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [LEN_W-1:0] len,
                        input int hold, input string tag);
        int                exp_lat;
        logic [DATA_W-1:0] exp_data;
        logic              exp_err;
        wr_t               exp_w [$];
        int                lat;
        logic [DATA_W-1:0] got_data;
        logic              got_err;

        exp_err  = (op == 2'b11);
        exp_lat  = 0;
        exp_data = '0;
        case (op)
            2'b00: begin exp_lat = 1; exp_data = model[addr]; end
            2'b01: begin
                exp_lat  = READBACK ? 2 : 1;
                exp_data = READBACK ? data : '0;
                exp_w.push_back('{a: addr, d: data});
            end
            2'b10: begin
                exp_lat  = int'(len);
                exp_data = DATA_W'(len);
                for (int i = 0; i < int'(len); i++)
                    exp_w.push_back('{a: ADDR_W'((int'(addr) + i) % DEPTH), d: data});
            end
            default: ;
        endcase

        @(negedge clock);
        wlog.delete();
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: req_ready=%b want 1", tag, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_len   = len;
        bus.rsp_ready = (hold < 0);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;

        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 2000) begin
            @(posedge clock); #1;
            lat++;
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles want %0d", tag, lat, exp_lat);
        end
        got_data = bus.rsp_data;
        got_err  = bus.rsp_err;
        n_tests++;
        if (got_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s rsp_data: got %h want %h", tag, got_data, exp_data);
        end
        n_tests++;
        if (got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s rsp_err: got %b want %b", tag, got_err, exp_err);
        end

        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 2'b01;
            bus.req_addr  = ADDR_W'($urandom);
            bus.req_data  = $urandom;
            @(posedge clock); #1;
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== got_data ||
                bus.rsp_err !== got_err || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall%0d: valid=%b data=%h err=%b ready=%b want 1 %h %b 0",
                         tag, i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.req_ready,
                         got_data, got_err);
            end
        end

        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s back_to_idle: valid=%b busy=%b ready=%b want 0 0 1",
                     tag, bus.rsp_valid, bus.busy, bus.req_ready);
        end
        bus.req_valid = 1'b0;

        n_tests++;
        if (wlog.size() !== exp_w.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wlog.size(), exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                n_tests++;
                if (wlog[i].a !== exp_w[i].a || wlog[i].d !== exp_w[i].d) begin
                    n_fail++;
                    $display("FAIL %s write%0d: got %0d:%h want %0d:%h", tag, i,
                             wlog[i].a, wlog[i].d, exp_w[i].a, exp_w[i].d);
                end
            end
        end
        foreach (exp_w[i]) model[exp_w[i].a] = exp_w[i].d;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.ram_write !== 1'b0 || bus.ram_addr !== '0 || bus.ram_value !== '0 ||
            bus.rsp_data !== '0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b busy=%b wr=%b addr=%h val=%h data=%h err=%b",
                     bus.req_ready, bus.rsp_valid, bus.busy, bus.ram_write, bus.ram_addr,
                     bus.ram_value, bus.rsp_data, bus.rsp_err);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        send(2'b01, 10'd5, 32'hDEADBEEF, '0, 0, "write5");
        send(2'b00, 10'd5, '0, '0, 0, "read5");
        n_tests++;
        if (model[5] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL model5: got %h want deadbeef", model[5]);
        end
    endtask

    task automatic test_fill_wrap();
        send(2'b10, 10'd1021, 32'hA5A5A5A5, 10'd5, 0, "fill_wrap");
        send(2'b00, 10'd0, '0, '0, 0, "read_wrap0");
    endtask

    task automatic test_fill_zero();
        send(2'b10, 10'd100, 32'h11111111, 10'd0, 0, "fill_zero");
    endtask

    task automatic test_illegal();
        send(2'b11, 10'd7, 32'hFFFFFFFF, 10'd3, 0, "illegal");
        send(2'b00, 10'd5, '0, '0, -1, "read_after_illegal");
    endtask

    task automatic test_back_to_back();
        send(2'b00, 10'd5, '0, '0, 4, "read_stall4");
        send(2'b01, 10'd6, 32'hCAFEF00D, '0, -1, "write_rdy_high");
        send(2'b00, 10'd6, '0, '0, -1, "read_rdy_high");
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clock);
        wlog.delete();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_addr  = 10'd200;
        bus.req_data  = 32'h5A5A0F0F;
        bus.req_len   = 10'd8;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.ram_write !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_fill: wr=%b busy=%b ready=%b want 0 0 1",
                     bus.ram_write, bus.busy, bus.req_ready);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_tests++;
        if (wlog.size() !== 2) begin
            n_fail++;
            $display("FAIL reset_fill_writes: got %0d want 2", wlog.size());
        end
        model[200] = 32'h5A5A0F0F;
        model[201] = 32'h5A5A0F0F;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_tests++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL after_reset%0d: valid=%b ready=%b want 0 1",
                         i, bus.rsp_valid, bus.req_ready);
            end
        end
        n_tests++;
        if (wlog.size() !== 2) begin
            n_fail++;
            $display("FAIL reset_no_more_writes: got %0d want 2", wlog.size());
        end
        send(2'b00, 10'd201, '0, '0, 0, "read_after_reset");
        send(2'b00, 10'd202, '0, '0, 0, "read_unwritten");
    endtask

    task automatic test_readback();
`ifdef RAM_MASTER_READBACK_EN
        send(2'b01, 10'd3, 32'h12345678, '0, 0, "readback_write3");
`endif
    endtask

    task automatic test_random();
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        int                pick;
        for (int t = 0; t < 60; t++) begin
            pick = int'($urandom_range(0, 9));
            op   = (pick < 4) ? 2'b00 : (pick < 7) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
            addr = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15))
                                               : ADDR_W'(1010 + $urandom_range(0, 13));
            send(op, addr, $urandom, LEN_W'($urandom_range(0, 12)),
                 int'($urandom_range(0, 4)) - 1, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = '0;
            model[i]   = '0;
        end
        idle_inputs();
        test_reset();
        test_write_read();
        test_fill_wrap();
        test_fill_zero();
        test_illegal();
        test_back_to_back();
        test_reset_mid_fill();
        test_readback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
